// File: rtl/pass_dist_pkg.sv
// rtl/pass_dist_pkg.sv - shared constants and FSM encoding for the pass distortion collector
package pass_dist_pkg;

  // Record type codes, in coding order within a bit-plane
  localparam logic [1:0] PASS_SP  = 2'd0;
  localparam logic [1:0] PASS_MRP = 2'd1;
  localparam logic [1:0] PASS_CP  = 2'd2;

  // Record field widths (distortion width is a top-level parameter)
  localparam int TYPE_W = 2;
  localparam int BP_W   = 4;
  localparam int ERR_W  = 31;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EMIT_SP  = 2'd1,
    EMIT_MRP = 2'd2,
    EMIT_CP  = 2'd3
  } state_t;

endpackage

// File: rtl/pass_rec_fifo.sv
// rtl/pass_rec_fifo.sv - synchronous record FIFO with full/empty and sync flush
module pass_rec_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Extra pointer bit distinguishes full from empty when the index bits match
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Full blocks a write even when a read happens the same cycle
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Head is forced to zero while empty so outputs show clean reset values
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; reset flushes the queue
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pass_dist_collect.sv
// rtl/pass_dist_collect.sv - serializes per-pass errors into cumulative distortion records (PASS_DIST_SAT_EN: saturating accumulator)
module pass_dist_collect
  import pass_dist_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIST_W     = 36
) (
  input  logic              clk_pass_pre,
  input  logic              rst_syn,
  input  logic [ERR_W-1:0]  pass_error_sp,
  input  logic [ERR_W-1:0]  pass_error_mrp,
  input  logic [ERR_W-1:0]  pass_error_cp,
  input  logic              pass_error_vld,
  input  logic [BP_W-1:0]   count_bp,
  input  logic              first_bp,
  input  logic              cb_last_bp,
  output logic              rec_vld,
  input  logic              rec_ready,
  output logic [TYPE_W-1:0] rec_type,
  output logic [BP_W-1:0]   rec_bp,
  output logic [DIST_W-1:0] rec_dist,
  output logic              rec_last,
  output logic              busy,
  output logic              drop_err
);

  localparam int REC_W = TYPE_W + BP_W + DIST_W + 1;

  state_t              state;
  state_t              state_nxt;
  logic [ERR_W-1:0]    cap_sp;
  logic [ERR_W-1:0]    cap_mrp;
  logic [ERR_W-1:0]    cap_cp;
  logic [BP_W-1:0]     cap_bp;
  logic                cap_last;
  logic [DIST_W-1:0]   acc;
  logic [DIST_W:0]     sum_wide;
  logic [DIST_W-1:0]   sum;
  logic [ERR_W-1:0]    err_sel;
  logic [TYPE_W-1:0]   type_sel;
  logic                wr_en;
  logic                wr_last;
  logic                fifo_full;
  logic                fifo_empty;
  logic [REC_W-1:0]    wr_rec;
  logic [REC_W-1:0]    rd_rec;

  // Next-state and record selection; a full FIFO holds the current pass
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_last   = 1'b0;
    err_sel   = '0;
    type_sel  = PASS_SP;
    case (state)
      IDLE: begin
        if (pass_error_vld) state_nxt = first_bp ? EMIT_CP : EMIT_SP;
      end
      EMIT_SP: begin
        err_sel  = cap_sp;
        type_sel = PASS_SP;
        if (!fifo_full) begin
          wr_en     = 1'b1;
          state_nxt = EMIT_MRP;
        end
      end
      EMIT_MRP: begin
        err_sel  = cap_mrp;
        type_sel = PASS_MRP;
        if (!fifo_full) begin
          wr_en     = 1'b1;
          state_nxt = EMIT_CP;
        end
      end
      EMIT_CP: begin
        err_sel  = cap_cp;
        type_sel = PASS_CP;
        wr_last  = cap_last;
        if (!fifo_full) begin
          wr_en     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Cumulative distortion including the pass being emitted
  always_comb begin
    sum_wide = {1'b0, acc} + {{(DIST_W + 1 - ERR_W){1'b0}}, err_sel};
`ifdef PASS_DIST_SAT_EN
    sum = sum_wide[DIST_W] ? {DIST_W{1'b1}} : sum_wide[DIST_W-1:0];
`else
    sum = sum_wide[DIST_W-1:0];
`endif
  end

  assign wr_rec = {type_sel, cap_bp, sum, wr_last};

  // FSM state register
  always_ff @(posedge clk_pass_pre) begin
    if (rst_syn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Capture the triple only when idle; strobes while busy are ignored here
  always_ff @(posedge clk_pass_pre) begin
    if (rst_syn) begin
      cap_sp   <= '0;
      cap_mrp  <= '0;
      cap_cp   <= '0;
      cap_bp   <= '0;
      cap_last <= 1'b0;
    end else if (state == IDLE && pass_error_vld) begin
      cap_sp   <= pass_error_sp;
      cap_mrp  <= pass_error_mrp;
      cap_cp   <= pass_error_cp;
      cap_bp   <= count_bp;
      cap_last <= cb_last_bp;
    end
  end

  // Accumulator advances on each write and clears after a code-block's final record
  always_ff @(posedge clk_pass_pre) begin
    if (rst_syn)    acc <= '0;
    else if (wr_en) acc <= wr_last ? '0 : sum;
  end

  // Sticky flag for triples lost because the serializer was busy
  always_ff @(posedge clk_pass_pre) begin
    if (rst_syn)                             drop_err <= 1'b0;
    else if (pass_error_vld && state != IDLE) drop_err <= 1'b1;
  end

  pass_rec_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk     (clk_pass_pre),
    .rst     (rst_syn),
    .wr_en   (wr_en),
    .wr_data (wr_rec),
    .rd_en   (rec_ready),
    .rd_data (rd_rec),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign {rec_type, rec_bp, rec_dist, rec_last} = rd_rec;
  assign rec_vld = !fifo_empty;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_pass_dist_collect.sv
// tb/tb_pass_dist_collect.sv - directed self-checking bench for pass_dist_collect
module tb_pass_dist_collect;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [30:0] e_sp = '0;
  logic [30:0] e_mrp = '0;
  logic [30:0] e_cp = '0;
  logic        e_vld = 1'b0;
  logic [3:0]  c_bp = '0;
  logic        f_bp = 1'b0;
  logic        l_bp = 1'b0;
  logic        rec_ready = 1'b0;
  logic        rec_vld;
  logic [1:0]  rec_type;
  logic [3:0]  rec_bp;
  logic [35:0] rec_dist;
  logic        rec_last;
  logic        busy;
  logic        drop_err;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] T_SP = 2'd0, T_MRP = 2'd1, T_CP = 2'd2;
  localparam logic [30:0] EMAX = 31'h7FFF_FFFF;

  typedef struct {
    logic [30:0] sp, mrp, cp;
    logic [3:0]  bp;
    logic        first, last;
    logic [35:0] d0, d1, d2;
  } vec_t;

  vec_t vec [6];

  pass_dist_collect dut (
    .clk_pass_pre   (clk),
    .rst_syn        (rst),
    .pass_error_sp  (e_sp),
    .pass_error_mrp (e_mrp),
    .pass_error_cp  (e_cp),
    .pass_error_vld (e_vld),
    .count_bp       (c_bp),
    .first_bp       (f_bp),
    .cb_last_bp     (l_bp),
    .rec_vld        (rec_vld),
    .rec_ready      (rec_ready),
    .rec_type       (rec_type),
    .rec_bp         (rec_bp),
    .rec_dist       (rec_dist),
    .rec_last       (rec_last),
    .busy           (busy),
    .drop_err       (drop_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [30:0] sp, input logic [30:0] mrp, input logic [30:0] cp,
                        input logic [3:0] bp, input logic first, input logic last);
    e_sp = sp; e_mrp = mrp; e_cp = cp; c_bp = bp; f_bp = first; l_bp = last;
    e_vld = 1'b1;
    tick();
    e_vld = 1'b0; f_bp = 1'b0; l_bp = 1'b0;
  endtask

  task automatic pop(input string name, input logic [1:0] t, input logic [3:0] bp,
                     input logic [35:0] d, input logic l);
    int w;
    w = 0;
    while (!rec_vld && w < 20) begin
      tick();
      w++;
    end
    if (!rec_vld) begin
      total++;
      bad++;
      $display("FAIL %s timeout: rec_vld got 0 expected 1", name);
    end else begin
      check({name, ".type"}, 64'(rec_type), 64'(t));
      check({name, ".bp"},   64'(rec_bp),   64'(bp));
      check({name, ".dist"}, 64'(rec_dist), 64'(d));
      check({name, ".last"}, 64'(rec_last), 64'(l));
      rec_ready = 1'b1;
      tick();
      rec_ready = 1'b0;
    end
  endtask

  initial begin
    vec[0] = '{sp: 31'd0,  mrp: 31'd0,  cp: 31'd100,  bp: 4'd9, first: 1'b1, last: 1'b0,
               d0: 36'd0,  d1: 36'd0,   d2: 36'd100};
    vec[1] = '{sp: 31'd10, mrp: 31'd20, cp: 31'd30,   bp: 4'd8, first: 1'b0, last: 1'b1,
               d0: 36'd110, d1: 36'd130, d2: 36'd160};
    vec[2] = '{sp: 31'd0,  mrp: 31'd0,  cp: 31'd0,    bp: 4'd7, first: 1'b0, last: 1'b0,
               d0: 36'd0,  d1: 36'd0,   d2: 36'd0};
    vec[3] = '{sp: 31'd5,  mrp: 31'd0,  cp: 31'd7,    bp: 4'd6, first: 1'b0, last: 1'b0,
               d0: 36'd5,  d1: 36'd5,   d2: 36'd12};
    vec[4] = '{sp: 31'd0,  mrp: 31'd0,  cp: 31'd1000, bp: 4'd3, first: 1'b1, last: 1'b1,
               d0: 36'd0,  d1: 36'd0,   d2: 36'd1012};
    vec[5] = '{sp: EMAX,   mrp: 31'd1,  cp: 31'd2,    bp: 4'd5, first: 1'b0, last: 1'b1,
               d0: 36'd2147483647, d1: 36'd2147483648, d2: 36'd2147483650};

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst.rec_vld",  64'(rec_vld),  64'd0);
    check("rst.rec_type", 64'(rec_type), 64'd0);
    check("rst.rec_bp",   64'(rec_bp),   64'd0);
    check("rst.rec_dist", 64'(rec_dist), 64'd0);
    check("rst.rec_last", 64'(rec_last), 64'd0);
    check("rst.busy",     64'(busy),     64'd0);
    check("rst.drop_err", 64'(drop_err), 64'd0);

    // Latency and busy window
    strobe(31'd1, 31'd2, 31'd3, 4'd4, 1'b0, 1'b1);
    check("lat.busy_t1", 64'(busy), 64'd1);
    check("lat.vld_t1",  64'(rec_vld), 64'd0);
    tick();
    check("lat.vld_t2",  64'(rec_vld), 64'd1);
    check("lat.busy_t2", 64'(busy), 64'd1);
    tick();
    tick();
    check("lat.busy_t4", 64'(busy), 64'd0);
    pop("lat.r0", T_SP,  4'd4, 36'd1, 1'b0);
    pop("lat.r1", T_MRP, 4'd4, 36'd3, 1'b0);
    pop("lat.r2", T_CP,  4'd4, 36'd6, 1'b1);

    // Table-driven bit-planes
    for (int i = 0; i < 6; i++) begin
      strobe(vec[i].sp, vec[i].mrp, vec[i].cp, vec[i].bp, vec[i].first, vec[i].last);
      if (vec[i].first) begin
        pop($sformatf("v%0d.cp", i), T_CP, vec[i].bp, vec[i].d2, vec[i].last);
      end else begin
        pop($sformatf("v%0d.sp", i),  T_SP,  vec[i].bp, vec[i].d0, 1'b0);
        pop($sformatf("v%0d.mrp", i), T_MRP, vec[i].bp, vec[i].d1, 1'b0);
        pop($sformatf("v%0d.cp", i),  T_CP,  vec[i].bp, vec[i].d2, vec[i].last);
      end
      repeat (2) tick();
      check($sformatf("v%0d.idle", i), 64'(busy), 64'd0);
    end

    // Backpressure: three bit-planes into an 8-deep FIFO
    strobe(31'd1, 31'd1, 31'd1, 4'd12, 1'b0, 1'b0);
    repeat (3) tick();
    strobe(31'd1, 31'd1, 31'd1, 4'd11, 1'b0, 1'b0);
    repeat (3) tick();
    strobe(31'd1, 31'd1, 31'd1, 4'd10, 1'b0, 1'b1);
    repeat (8) tick();
    check("full.stalled", 64'(busy), 64'd1);
    for (int k = 0; k < 9; k++) begin
      pop($sformatf("full.r%0d", k), 2'(k % 3), 4'(12 - k / 3), 36'(k + 1), k == 8);
    end
    tick();
    check("full.drained", 64'(rec_vld), 64'd0);
    check("full.idle",    64'(busy),    64'd0);

    // Strobe while busy is dropped
    strobe(31'd1, 31'd1, 31'd1, 4'd2, 1'b0, 1'b1);
    strobe(31'd50, 31'd50, 31'd50, 4'd1, 1'b0, 1'b0);
    check("drop.flag", 64'(drop_err), 64'd1);
    pop("drop.r0", T_SP,  4'd2, 36'd1, 1'b0);
    pop("drop.r1", T_MRP, 4'd2, 36'd2, 1'b0);
    pop("drop.r2", T_CP,  4'd2, 36'd3, 1'b1);
    repeat (5) tick();
    check("drop.no_extra", 64'(rec_vld),  64'd0);
    check("drop.sticky",   64'(drop_err), 64'd1);

    // Accumulator overflow: 30 maximal passes drained, then inspect the last three
    rec_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      strobe(EMAX, EMAX, EMAX, 4'd15, 1'b0, 1'b0);
      repeat (3) tick();
    end
    repeat (3) tick();
    rec_ready = 1'b0;
    check("ovf.drained", 64'(rec_vld), 64'd0);
    strobe(EMAX, EMAX, EMAX, 4'd14, 1'b0, 1'b1);
    pop("ovf.sp",  T_SP,  4'd14, 36'd66571993057, 1'b0);
    pop("ovf.mrp", T_MRP, 4'd14, 36'd68719476704, 1'b0);
`ifdef PASS_DIST_SAT_EN
    pop("ovf.cp",  T_CP,  4'd14, 36'd68719476735, 1'b1);
`else
    pop("ovf.cp",  T_CP,  4'd14, 36'd2147483615, 1'b1);
`endif
    strobe(31'd0, 31'd0, 31'd5, 4'd13, 1'b1, 1'b0);
    pop("ovf.next", T_CP, 4'd13, 36'd5, 1'b0);

    // Reset during EMIT_MRP with two records queued and a simultaneous strobe
    strobe(31'd0, 31'd0, 31'd7, 4'd9, 1'b1, 1'b0);
    repeat (3) tick();
    strobe(31'd1, 31'd2, 31'd3, 4'd8, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    e_vld = 1'b1;
    tick();
    rst = 1'b0;
    e_vld = 1'b0;
    check("mid.rec_vld",  64'(rec_vld),  64'd0);
    check("mid.rec_type", 64'(rec_type), 64'd0);
    check("mid.rec_bp",   64'(rec_bp),   64'd0);
    check("mid.rec_dist", 64'(rec_dist), 64'd0);
    check("mid.rec_last", 64'(rec_last), 64'd0);
    check("mid.busy",     64'(busy),     64'd0);
    check("mid.drop_err", 64'(drop_err), 64'd0);
    repeat (4) tick();
    check("mid.quiet", 64'(rec_vld), 64'd0);
    strobe(31'd0, 31'd0, 31'd4, 4'd6, 1'b1, 1'b0);
    pop("mid.acc_clear", T_CP, 4'd6, 36'd4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, simulation stopped");
    $fatal(1);
  end

endmodule

// File: doc/pass_dist_collect.md
# pass_dist_collect

Consumer end of the per-pass distortion interface. Accepts the three pass-error values (significance propagation, magnitude refinement, cleanup) produced once per bit-plane, serializes them into per-pass records in coding order, and accumulates cumulative distortion reduction per code-block. Records are buffered in a small FIFO and handed to the rate-control / truncation-point selector over a valid/ready handshake.

## Interface
- FIFO_DEPTH, 8, record FIFO depth; power of two, ≥2
- DIST_W, 36, cumulative distortion width; ≥31
- clk_pass_pre  in  1  clock
- rst_syn  in  1  synchronous, active-high reset
- pass_error_sp  in  31  SP pass distortion for the current bit-plane, unsigned
- pass_error_mrp  in  31  MRP pass distortion, unsigned
- pass_error_cp  in  31  CP pass distortion, unsigned
- pass_error_vld  in  1  one-cycle strobe; triple valid
- count_bp  in  4  bit-plane index of the triple
- first_bp  in  1  with strobe: most significant coded bit-plane (CP only)
- cb_last_bp  in  1  with strobe: final bit-plane of code-block
- rec_vld  out  1  record available
- rec_ready  in  1  consumer accepts record
- rec_type  out  2  0=SP, 1=MRP, 2=CP
- rec_bp  out  4  bit-plane of record
- rec_dist  out  DIST_W  cumulative distortion including this pass
- rec_last  out  1  final record of code-block
- busy  out  1  serializer not idle
- drop_err  out  1  sticky: strobe arrived while busy

## Operation
- FSM states: IDLE, EMIT_SP, EMIT_MRP, EMIT_CP.
- IDLE + pass_error_vld: capture triple, count_bp, first_bp, cb_last_bp; go EMIT_CP if first_bp else EMIT_SP.
- EMIT_x: when FIFO not full, write record {type, bp, acc + pass_error_x, last}; acc <= acc + pass_error_x; advance SP→MRP→CP→IDLE. FIFO full: hold state, no write, acc unchanged.
- last = 1 only on CP record of a triple captured with cb_last_bp; on that write acc clears to 0.
- Zero-valued passes still emit a record (rec_dist unchanged from previous).
- pass_error_vld while busy: triple dropped, drop_err set; cleared only by rst_syn.
- Addition unsigned; pass error zero-extended to DIST_W.
- FIFO: write and read in same cycle both take effect when not full/empty; full blocks write even if a read occurs that cycle (no bypass). Outputs show head entry; rec_vld = not empty.

## Timing
- Strobe at cycle T → first record written at T+1, visible on rec_vld at T+2 (registered FIFO head).
- Normal bit-plane: 3 write cycles; first_bp: 1. busy high from T+1 until the cycle after the last write.
- Back-to-back strobes spaced ≥4 cycles accepted with unblocked FIFO.
- Reset values: rec_vld 0, rec_type 0, rec_bp 0, rec_dist 0, rec_last 0, busy 0, drop_err 0; FSM IDLE, acc 0, FIFO empty.
- rst_syn mid-emission: FSM to IDLE, FIFO flushed, acc cleared same edge; reset dominates simultaneous strobe.

## Configuration
- PASS_DIST_SAT_EN defined: accumulator saturates at 2^DIST_W−1; stays there until code-block end clears it.
- Undefined: accumulator wraps modulo 2^DIST_W.

## Structure
- Shared package pass_dist_pkg: pass-type constants (PASS_SP, PASS_MRP, PASS_CP), record field widths, FSM state encoding.
- One sub-module: pass_rec_fifo (synchronous FIFO, parameterized depth/width, full/empty, sync reset flush).
- Top holds FSM, capture registers, accumulator.

## Test plan
- first_bp strobe, cp=100, cb_last_bp=0 → single record {CP, bp, 100, last=0}.
- Next strobe sp=10, mrp=20, cp=30, cb_last_bp=1 → records dist 110, 130, 160; last=1 on 160; next block starts from 0.
- rec_ready held low, FIFO_DEPTH=8, three full bit-planes → 8 records stored, serializer stalls, ninth written after one read, no loss.
- Strobe issued 1 cycle after previous strobe → second triple dropped, drop_err=1, first triple's records intact.
- Accumulator near max (sum of 2^31−1 values) → with PASS_DIST_SAT_EN rec_dist pinned at 2^DIST_W−1; without, wraps.
- rst_syn during EMIT_MRP with 2 records queued → all outputs reset values next cycle, FIFO empty, busy 0.
